// File: rtl/decode_stage_if.sv
// FE/DE inputs, writeback/resolve inputs, stall feedback and DE/EX latch outputs of the decode stage.
interface decode_stage_if;
    logic        I_LOCK;
    logic [15:0] I_PC;
    logic [31:0] I_IR;
    logic        I_FetchStall;
    logic        I_WBEnable;
    logic [3:0]  I_WBDestReg;
    logic [15:0] I_WBValue;
    logic        I_BranchAddrSelect;
    logic        O_BranchStallSignal;
    logic        O_DepStallSignal;
    logic        O_LOCK;
    logic [15:0] O_PC;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestReg;
    logic        O_DestValid;
    logic [15:0] O_Src1Value;
    logic [15:0] O_Src2Value;
    logic [15:0] O_Imm;
    logic        O_DecodeStall;

    modport slave (
        input  I_LOCK, I_PC, I_IR, I_FetchStall, I_WBEnable, I_WBDestReg, I_WBValue, I_BranchAddrSelect,
        output O_BranchStallSignal, O_DepStallSignal, O_LOCK, O_PC, O_Opcode, O_DestReg, O_DestValid,
               O_Src1Value, O_Src2Value, O_Imm, O_DecodeStall
    );

    modport master (
        output I_LOCK, I_PC, I_IR, I_FetchStall, I_WBEnable, I_WBDestReg, I_WBValue, I_BranchAddrSelect,
        input  O_BranchStallSignal, O_DepStallSignal, O_LOCK, O_PC, O_Opcode, O_DestReg, O_DestValid,
               O_Src1Value, O_Src2Value, O_Imm, O_DecodeStall
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: field decode, 16x16 register file, per-register in-flight scoreboard, branch-wait FSM, DE/EX latch.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into source reads and the dependency check.
module decode_stage #(
    parameter int NUM_REGS = 16,
    parameter int SB_MAX   = 3
) (
    input logic           I_CLOCK,
    input logic           I_RESET,
    decode_stage_if.slave bus
);
    localparam logic [1:0] SB_FULL = 2'(SB_MAX);

    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} br_state_t;
    br_state_t state_reg, state_next;

    logic [15:0] rf_reg   [NUM_REGS];
    logic [1:0]  cnt_reg  [NUM_REGS];
    logic [1:0]  cnt_view [NUM_REGS];
    logic [NUM_REGS-1:0] cnt_inc, cnt_dec;

    logic [7:0] op;
    logic [3:0] dest_idx, src1_idx, src2_idx;
    logic is_alu_reg, is_alu_imm, is_ldw, is_stw, is_br, is_jmp, is_known;
    logic has_dest, reads1, reads2, valid, dep_stall, issue;
    logic [15:0] src1_val, src2_val;

    assign op         = bus.I_IR[31:24];
    assign dest_idx   = bus.I_IR[23:20];
    assign src1_idx   = bus.I_IR[19:16];
    assign is_alu_reg = (op[7:4] == 4'h0);
    assign is_alu_imm = (op[7:4] == 4'h1);
    assign is_ldw     = (op == 8'h40);
    assign is_stw     = (op == 8'h41);
    assign is_br      = (op[7:3] == 5'b00100);
    assign is_jmp     = (op == 8'h28);
    assign is_known   = is_alu_reg | is_alu_imm | is_ldw | is_stw | is_br | is_jmp;
    assign has_dest   = is_alu_reg | is_alu_imm | is_ldw;
    assign reads1     = is_alu_reg | is_alu_imm | is_ldw | is_stw | is_jmp;
    assign reads2     = is_alu_reg | is_stw;
    // Stores carry their data register in the dest field.
    assign src2_idx   = is_stw ? dest_idx : bus.I_IR[11:8];
    assign valid      = bus.I_LOCK & ~bus.I_FetchStall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            assign cnt_dec[gi] = bus.I_WBEnable && (bus.I_WBDestReg == 4'(gi)) && (cnt_reg[gi] != 2'd0);
            assign cnt_inc[gi] = issue && has_dest && (dest_idx == 4'(gi));
`ifdef DECODE_WB_BYPASS_EN
            assign cnt_view[gi] = cnt_reg[gi] - {1'b0, cnt_dec[gi]};
`else
            assign cnt_view[gi] = cnt_reg[gi];
`endif
        end
    endgenerate

`ifdef DECODE_WB_BYPASS_EN
    assign src1_val = (bus.I_WBEnable && bus.I_WBDestReg == src1_idx) ? bus.I_WBValue : rf_reg[src1_idx];
    assign src2_val = (bus.I_WBEnable && bus.I_WBDestReg == src2_idx) ? bus.I_WBValue : rf_reg[src2_idx];
`else
    assign src1_val = rf_reg[src1_idx];
    assign src2_val = rf_reg[src2_idx];
`endif

    assign dep_stall = valid && (state_reg == RUN) &&
                       ((reads1 && cnt_view[src1_idx] != 2'd0) ||
                        (reads2 && cnt_view[src2_idx] != 2'd0) ||
                        (has_dest && cnt_view[dest_idx] == SB_FULL));
    assign issue     = valid && !dep_stall && (state_reg == RUN);

    assign bus.O_DepStallSignal    = dep_stall;
    assign bus.O_BranchStallSignal = (valid && (is_br || is_jmp) && state_reg == RUN) || (state_reg == BR_WAIT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (issue && (is_br || is_jmp)) state_next = BR_WAIT;
            BR_WAIT: if (bus.I_BranchAddrSelect) state_next = RUN;
            default: state_next = RUN;
        endcase
        if (!bus.I_LOCK) state_next = RUN;
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) state_reg <= RUN;
        else         state_reg <= state_next;
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= 16'h0;
        end else if (bus.I_WBEnable) begin
            rf_reg[bus.I_WBDestReg] <= bus.I_WBValue;
        end
    end

    // Issue and retire to the same register cancel; a retire at zero is dropped.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!bus.I_LOCK) cnt_reg[i] <= 2'd0;
                else case ({cnt_inc[i], cnt_dec[i]})
                    2'b10:   cnt_reg[i] <= cnt_reg[i] + 2'd1;
                    2'b01:   cnt_reg[i] <= cnt_reg[i] - 2'd1;
                    default: cnt_reg[i] <= cnt_reg[i];
                endcase
            end
        end
    end

    logic        lock_reg, dest_valid_reg, stall_reg;
    logic [15:0] pc_reg, src1_reg, src2_reg, imm_reg;
    logic [7:0]  opcode_reg;
    logic [3:0]  dest_reg;

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lock_reg       <= 1'b0;
            pc_reg         <= 16'h4;
            opcode_reg     <= 8'hFF;
            dest_reg       <= 4'h0;
            dest_valid_reg <= 1'b0;
            src1_reg       <= 16'h0;
            src2_reg       <= 16'h0;
            imm_reg        <= 16'h0;
            stall_reg      <= 1'b1;
        end else begin
            lock_reg       <= bus.I_LOCK;
            stall_reg      <= ~issue;
            dest_valid_reg <= issue & has_dest;
            if (issue) begin
                pc_reg     <= bus.I_PC;
                opcode_reg <= is_known ? op : 8'hFF;
                dest_reg   <= dest_idx;
                src1_reg   <= src1_val;
                src2_reg   <= src2_val;
                imm_reg    <= bus.I_IR[15:0];
            end
        end
    end

    assign bus.O_LOCK        = lock_reg;
    assign bus.O_PC          = pc_reg;
    assign bus.O_Opcode      = opcode_reg;
    assign bus.O_DestReg     = dest_reg;
    assign bus.O_DestValid   = dest_valid_reg;
    assign bus.O_Src1Value   = src1_reg;
    assign bus.O_Src2Value   = src2_reg;
    assign bus.O_Imm         = imm_reg;
    assign bus.O_DecodeStall = stall_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a reference model of the decode rules.
module tb_decode_stage;
    logic clk;
    logic rst;
    decode_stage_if bus();

    decode_stage #(.NUM_REGS(16), .SB_MAX(3)) dut (.I_CLOCK(clk), .I_RESET(rst), .bus(bus));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int          m_cnt [16];
    logic [15:0] m_rf  [16];
    bit          m_wait;
    bit          m_issue;
    logic        e_lock, e_dv, e_ds, e_br, e_dep;
    logic [15:0] e_pc, e_s1, e_s2, e_imm;
    logic [7:0]  e_op;
    logic [3:0]  e_dest;
    logic        o_br, o_dep;

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, 4'h0, s2, 8'h5A};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i] = 0;
            m_rf[i]  = 16'h0;
        end
        m_wait = 0; m_issue = 0;
        e_lock = 0; e_pc = 16'h4; e_op = 8'hFF; e_dest = 0; e_dv = 0;
        e_s1 = 0; e_s2 = 0; e_imm = 0; e_ds = 1;
    endtask

    // Writers still outstanding on r as seen by this cycle's check.
    function automatic int pending(input int r);
        int p = m_cnt[r];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.I_WBEnable && int'(bus.I_WBDestReg) == r && p > 0) p = p - 1;
`endif
        return p;
    endfunction

    function automatic logic [15:0] read_reg(input int r);
`ifdef DECODE_WB_BYPASS_EN
        if (bus.I_WBEnable && int'(bus.I_WBDestReg) == r) return bus.I_WBValue;
`endif
        return m_rf[r];
    endfunction

    task automatic drive(input logic lock, input logic fstall, input logic [31:0] ir, input logic [15:0] pc,
                         input logic wben, input logic [3:0] wbreg, input logic [15:0] wbval, input logic bas);
        bus.I_LOCK = lock; bus.I_FetchStall = fstall; bus.I_IR = ir; bus.I_PC = pc;
        bus.I_WBEnable = wben; bus.I_WBDestReg = wbreg; bus.I_WBValue = wbval; bus.I_BranchAddrSelect = bas;
    endtask

    // Predict this cycle from the model, sample the stall lines, advance one negedge.
    task automatic tick();
        int op, d, s1, s2, s2i, wr;
        bit v, areg, aimm, ldw, stw, br, jmp, hd, r1, r2, dep, iss;
        op = int'(bus.I_IR[31:24]); d = int'(bus.I_IR[23:20]); s1 = int'(bus.I_IR[19:16]); s2 = int'(bus.I_IR[11:8]);
        wr = int'(bus.I_WBDestReg);
        v    = bus.I_LOCK && !bus.I_FetchStall;
        areg = op < 16;
        aimm = op >= 16 && op < 32;
        br   = op >= 32 && op < 40;
        jmp  = op == 40;
        ldw  = op == 64;
        stw  = op == 65;
        hd   = areg || aimm || ldw;
        r1   = areg || aimm || ldw || stw || jmp;
        r2   = areg || stw;
        s2i  = stw ? d : s2;
        dep  = v && !m_wait && ((r1 && pending(s1) > 0) || (r2 && pending(s2i) > 0) || (hd && pending(d) >= 3));
        iss  = v && !m_wait && !dep;
        e_dep = dep;
        e_br  = m_wait || (v && (br || jmp));
        e_lock = bus.I_LOCK;
        e_ds   = !iss;
        e_dv   = iss && hd;
        if (iss) begin
            e_pc   = bus.I_PC;
            e_op   = (areg || aimm || ldw || stw || br || jmp) ? 8'(op) : 8'hFF;
            e_dest = 4'(d);
            e_s1   = read_reg(s1);
            e_s2   = read_reg(s2i);
            e_imm  = bus.I_IR[15:0];
        end
        if (!bus.I_LOCK) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_wait = 0;
        end else begin
            if (bus.I_WBEnable && m_cnt[wr] > 0) m_cnt[wr] = m_cnt[wr] - 1;
            if (iss && hd) m_cnt[d] = m_cnt[d] + 1;
            if (m_wait && bus.I_BranchAddrSelect) m_wait = 0;
            else if (iss && (br || jmp)) m_wait = 1;
        end
        if (bus.I_WBEnable) m_rf[wr] = bus.I_WBValue;
        m_issue = iss;
        $display("txn t=%0t lock=%0b ir=%h wb=%0b r%0d=%h issue=%0b", $time, bus.I_LOCK && !bus.I_FetchStall, bus.I_IR,
                 bus.I_WBEnable, wr, bus.I_WBValue, iss);
        #1;
        o_br  = bus.O_BranchStallSignal;
        o_dep = bus.O_DepStallSignal;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1, 32'hFF00_0000, 16'h0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0, mk(8'h10, 4'd3, 4'd0, 4'd0), 16'h0100, 0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.O_DestValid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_issue: got %b want 1", bus.O_DestValid); end
        drive(1, 0, mk(8'h10, 4'd7, 4'd3, 4'd0), 16'h0104, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.O_LOCK !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b want 0", bus.O_LOCK); end
        n_cmp++; if (bus.O_PC !== 16'h4) begin n_bad++; $display("FAIL rst_pc: got %h want 0004", bus.O_PC); end
        n_cmp++; if (bus.O_Opcode !== 8'hFF) begin n_bad++; $display("FAIL rst_op: got %h want ff", bus.O_Opcode); end
        n_cmp++; if (bus.O_DestReg !== 4'h0) begin n_bad++; $display("FAIL rst_dest: got %h want 0", bus.O_DestReg); end
        n_cmp++; if (bus.O_DestValid !== 1'b0) begin n_bad++; $display("FAIL rst_dv: got %b want 0", bus.O_DestValid); end
        n_cmp++; if (bus.O_Src1Value !== 16'h0 || bus.O_Src2Value !== 16'h0) begin n_bad++; $display("FAIL rst_src: got %h/%h want 0/0", bus.O_Src1Value, bus.O_Src2Value); end
        n_cmp++; if (bus.O_Imm !== 16'h0) begin n_bad++; $display("FAIL rst_imm: got %h want 0", bus.O_Imm); end
        n_cmp++; if (bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b want 1", bus.O_DecodeStall); end
        n_cmp++; if (bus.O_DepStallSignal !== 1'b0) begin n_bad++; $display("FAIL rst_cnt3: dep got %b want 0", bus.O_DepStallSignal); end
        n_cmp++; if (bus.O_BranchStallSignal !== 1'b0) begin n_bad++; $display("FAIL rst_fsm: br got %b want 0", bus.O_BranchStallSignal); end
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        n_cmp++; if (bus.O_DecodeStall !== 1'b0 || bus.O_DestReg !== 4'd7) begin n_bad++; $display("FAIL rst_after_issue: got stall=%b dest=%h want 0/7", bus.O_DecodeStall, bus.O_DestReg); end
    endtask

    task automatic test_alu();
        do_reset();
        drive(1, 1, 32'hFF00_0000, 16'h0, 1, 4'd2, 16'd5, 0); tick();
        drive(1, 1, 32'hFF00_0000, 16'h0, 1, 4'd3, 16'd7, 0); tick();
        drive(1, 0, mk(8'h01, 4'd1, 4'd2, 4'd3), 16'h0104, 0, 0, 0, 0); tick();
        n_cmp++; if (o_dep !== 1'b0) begin n_bad++; $display("FAIL alu_dep: got %b want 0", o_dep); end
        n_cmp++; if (bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", bus.O_DecodeStall); end
        n_cmp++; if (bus.O_Src1Value !== 16'd5) begin n_bad++; $display("FAIL alu_src1: got %h want 0005", bus.O_Src1Value); end
        n_cmp++; if (bus.O_Src2Value !== 16'd7) begin n_bad++; $display("FAIL alu_src2: got %h want 0007", bus.O_Src2Value); end
        n_cmp++; if (bus.O_DestReg !== 4'd1 || bus.O_DestValid !== 1'b1) begin n_bad++; $display("FAIL alu_dest: got %h/%b want 1/1", bus.O_DestReg, bus.O_DestValid); end
        n_cmp++; if (bus.O_PC !== 16'h0104 || bus.O_LOCK !== 1'b1) begin n_bad++; $display("FAIL alu_pc: got %h/%b want 0104/1", bus.O_PC, bus.O_LOCK); end
        drive(1, 0, mk(8'h10, 4'd8, 4'd9, 4'd0), 16'h0108, 0, 0, 0, 0); tick();
        n_cmp++; if (bus.O_DecodeStall !== 1'b0 || bus.O_Opcode !== 8'h10 || bus.O_PC !== 16'h0108) begin n_bad++; $display("FAIL alu_b2b: got stall=%b op=%h pc=%h want 0/10/0108", bus.O_DecodeStall, bus.O_Opcode, bus.O_PC); end
        drive(1, 0, mk(8'h12, 4'd2, 4'd1, 4'd0), 16'h010C, 0, 0, 0, 0); tick();
        n_cmp++; if (o_dep !== 1'b1 || bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL alu_cnt1: got dep=%b stall=%b want 1/1", o_dep, bus.O_DecodeStall); end
    endtask

    task automatic test_dep();
        do_reset();
        drive(1, 0, mk(8'h10, 4'd1, 4'd0, 4'd0), 16'h0200, 0, 0, 0, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, mk(8'h11, 4'd2, 4'd1, 4'd0), 16'h0204, 0, 0, 0, 0); tick();
            n_cmp++; if (o_dep !== 1'b1 || bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL dep_wait%0d: got dep=%b stall=%b want 1/1", k, o_dep, bus.O_DecodeStall); end
        end
        drive(1, 0, mk(8'h11, 4'd2, 4'd1, 4'd0), 16'h0204, 1, 4'd1, 16'h00AA, 0); tick();
`ifdef DECODE_WB_BYPASS_EN
        n_cmp++; if (o_dep !== 1'b0 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL dep_wbcycle: got dep=%b stall=%b want 0/0", o_dep, bus.O_DecodeStall); end
`else
        n_cmp++; if (o_dep !== 1'b1 || bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL dep_wbcycle: got dep=%b stall=%b want 1/1", o_dep, bus.O_DecodeStall); end
        drive(1, 0, mk(8'h11, 4'd2, 4'd1, 4'd0), 16'h0204, 0, 0, 0, 0); tick();
        n_cmp++; if (o_dep !== 1'b0 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL dep_after: got dep=%b stall=%b want 0/0", o_dep, bus.O_DecodeStall); end
`endif
        n_cmp++; if (bus.O_Src1Value !== 16'h00AA) begin n_bad++; $display("FAIL dep_value: got %h want 00aa", bus.O_Src1Value); end
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 0, mk(8'h20, 4'd0, 4'd0, 4'd0), 16'h0300, 0, 0, 0, 0); tick();
        n_cmp++; if (o_br !== 1'b1 || bus.O_DecodeStall !== 1'b0 || bus.O_Opcode !== 8'h20) begin n_bad++; $display("FAIL br_issue: got br=%b stall=%b op=%h want 1/0/20", o_br, bus.O_DecodeStall, bus.O_Opcode); end
        for (int k = 0; k < 3; k++) begin
            drive(1, k[0], mk(8'h10, 4'd3, 4'd0, 4'd0), 16'h0304, 0, 0, 0, 0); tick();
            n_cmp++; if (o_br !== 1'b1 || bus.O_DecodeStall !== 1'b1 || bus.O_DestValid !== 1'b0) begin n_bad++; $display("FAIL br_wait%0d: got br=%b stall=%b dv=%b want 1/1/0", k, o_br, bus.O_DecodeStall, bus.O_DestValid); end
        end
        drive(1, 0, mk(8'h10, 4'd3, 4'd0, 4'd0), 16'h0304, 0, 0, 0, 1); tick();
        n_cmp++; if (o_br !== 1'b1 || bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL br_resolve: got br=%b stall=%b want 1/1", o_br, bus.O_DecodeStall); end
        drive(1, 0, mk(8'h10, 4'd3, 4'd0, 4'd0), 16'h0304, 0, 0, 0, 0); tick();
        n_cmp++; if (o_br !== 1'b0 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL br_run: got br=%b stall=%b want 0/0", o_br, bus.O_DecodeStall); end
        drive(1, 0, mk(8'h28, 4'd0, 4'd0, 4'd0), 16'h0308, 0, 0, 0, 0); tick();
        n_cmp++; if (bus.O_Opcode !== 8'h28 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL jmp_issue: got op=%h stall=%b want 28/0", bus.O_Opcode, bus.O_DecodeStall); end
        drive(1, 0, mk(8'h10, 4'd6, 4'd0, 4'd0), 16'h030C, 0, 0, 0, 0); tick();
        n_cmp++; if (o_br !== 1'b1) begin n_bad++; $display("FAIL jmp_wait: got br=%b want 1", o_br); end
        do_reset();
        drive(1, 0, mk(8'h10, 4'd6, 4'd0, 4'd0), 16'h030C, 0, 0, 0, 0); tick();
        n_cmp++; if (o_br !== 1'b0 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL br_reset: got br=%b stall=%b want 0/0", o_br, bus.O_DecodeStall); end
    endtask

    task automatic test_sb_full();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, mk(8'h10, 4'd4, 4'd0, 4'd0), 16'h0400, 0, 0, 0, 0); tick();
            n_cmp++; if (bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL sb_fill%0d: got stall=%b want 0", k, bus.O_DecodeStall); end
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, mk(8'h10, 4'd4, 4'd0, 4'd0), 16'h0404, 0, 0, 0, 0); tick();
            n_cmp++; if (o_dep !== 1'b1 || bus.O_DecodeStall !== 1'b1) begin n_bad++; $display("FAIL sb_full%0d: got dep=%b stall=%b want 1/1", k, o_dep, bus.O_DecodeStall); end
        end
        drive(1, 0, mk(8'h10, 4'd4, 4'd0, 4'd0), 16'h0404, 1, 4'd4, 16'h1234, 0); tick();
`ifndef DECODE_WB_BYPASS_EN
        n_cmp++; if (o_dep !== 1'b1) begin n_bad++; $display("FAIL sb_wbcycle: got dep=%b want 1", o_dep); end
        drive(1, 0, mk(8'h10, 4'd4, 4'd0, 4'd0), 16'h0404, 0, 0, 0, 0); tick();
`endif
        n_cmp++; if (o_dep !== 1'b0 || bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL sb_issue4: got dep=%b stall=%b want 0/0", o_dep, bus.O_DecodeStall); end
        drive(1, 0, mk(8'h10, 4'd4, 4'd0, 4'd0), 16'h0408, 0, 0, 0, 0); tick();
        n_cmp++; if (o_dep !== 1'b1) begin n_bad++; $display("FAIL sb_cnt3: got dep=%b want 1", o_dep); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1, 0, mk(8'h10, 4'd5, 4'd0, 4'd0), 16'h0500, 0, 0, 0, 0); tick();
        drive(1, 0, mk(8'h10, 4'd5, 4'd0, 4'd0), 16'h0504, 1, 4'd5, 16'h0055, 0); tick();
        n_cmp++; if (bus.O_DecodeStall !== 1'b0) begin n_bad++; $display("FAIL same_issue: got stall=%b want 0", bus.O_DecodeStall); end
        drive(1, 1, 32'hFF00_0000, 16'h0, 1, 4'd5, 16'h0056, 0); tick();
        drive(1, 0, mk(8'h11, 4'd6, 4'd5, 4'd0), 16'h0508, 0, 0, 0, 0); tick();
        n_cmp++; if (o_dep !== 1'b0 || bus.O_DecodeStall !== 1'b0 || bus.O_Src1Value !== 16'h0056) begin n_bad++; $display("FAIL same_cnt5: got dep=%b stall=%b src1=%h want 0/0/0056", o_dep, bus.O_DecodeStall, bus.O_Src1Value); end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [7:0] op;
        case ($urandom_range(0, 7))
            0: op = 8'($urandom_range(0, 15));
            1: op = 8'($urandom_range(16, 31));
            2: op = 8'h40;
            3: op = 8'h41;
            4: op = 8'($urandom_range(32, 39));
            5: op = 8'h28;
            6: op = 8'hFF;
            default: op = 8'($urandom_range(48, 63));
        endcase
        return {op, 1'b0, 3'($urandom), 1'b0, 3'($urandom), 4'($urandom), 1'b0, 3'($urandom), 8'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] ir;
        bit          held;
        logic        wben;
        logic [3:0]  wbreg;
        int          start;
        int          errs;
        do_reset();
        held = 0; ir = 32'hFF00_0000; errs = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!held) ir = rand_ir();
            wben = 0; wbreg = 0;
            if ($urandom_range(0, 1) == 1) begin
                start = int'($urandom_range(0, 15));
                for (int k = 0; k < 16; k++)
                    if (!wben && m_cnt[(start + k) % 16] > 0) begin wben = 1; wbreg = 4'((start + k) % 16); end
            end
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0, ir, 16'($urandom), wben, wbreg, 16'($urandom),
                  m_wait && $urandom_range(0, 3) == 0);
            tick();
            held = !m_issue;
            n_cmp++;
            if (o_br !== e_br || o_dep !== e_dep || bus.O_LOCK !== e_lock || bus.O_DecodeStall !== e_ds ||
                bus.O_DestValid !== e_dv || bus.O_PC !== e_pc || bus.O_Opcode !== e_op || bus.O_DestReg !== e_dest ||
                bus.O_Src1Value !== e_s1 || bus.O_Src2Value !== e_s2 || bus.O_Imm !== e_imm) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_c%0d: got br=%b dep=%b lk=%b ds=%b dv=%b pc=%h op=%h d=%h s1=%h s2=%h imm=%h want %b %b %b %b %b %h %h %h %h %h %h",
                             c, o_br, o_dep, bus.O_LOCK, bus.O_DecodeStall, bus.O_DestValid, bus.O_PC, bus.O_Opcode, bus.O_DestReg,
                             bus.O_Src1Value, bus.O_Src2Value, bus.O_Imm, e_br, e_dep, e_lock, e_ds, e_dv, e_pc, e_op, e_dest, e_s1, e_s2, e_imm);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1, 32'hFF00_0000, 16'h0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_dep();
        test_branch();
        test_sb_full();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
